// File: rtl/tmr_voter_seq.sv
// Registered triple-modular-redundancy voter with per-lane persistence FSMs.
// It degrades through DMR and simplex voting as lanes are retired.
module tmr_voter_seq #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned PERSIST   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       data_1,
    input  logic [WIDTH-1:0]       data_2,
    input  logic [WIDTH-1:0]       data_3,
    input  logic                   clear_err,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       tmr_out,
    output logic                   mismatch,
    output logic [2:0]             err_lane,
    output logic                   multi_err,
    output logic                   uncorrectable,
    output logic [2:0]             lane_fault,
    output logic [3*CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned RunW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {StNormal, StSuspect, StFaulty} lane_st_e;

    lane_st_e             st_q  [3];
    lane_st_e             st_d  [3];
    logic [RunW-1:0]      run_q [3];
    logic [RunW-1:0]      run_d [3];
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];

    logic [WIDTH-1:0] lane [3];
    logic [WIDTH-1:0] tmr_out_q, res, ha, hb;
    logic             out_valid_q, mismatch_q, multi_err_q, uncorrectable_q;
    logic [2:0]       err_lane_q, dis, lf;
    logic             unc, mm, advance, found;
    logic [1:0]       nf;

    assign lane[0] = data_1;
    assign lane[1] = data_2;
    assign lane[2] = data_3;

    always_comb begin
        for (int i = 0; i < 3; i++) lf[i] = (st_q[i] == StFaulty);
    end

    always_comb begin
        res     = tmr_out_q;
        dis     = 3'b000;
        unc     = 1'b0;
        mm      = 1'b0;
        advance = 1'b0;
        ha      = '0;
        hb      = '0;
        found   = 1'b0;
        nf      = {1'b0, lf[0]} + {1'b0, lf[1]} + {1'b0, lf[2]};
        // ha/hb are the first and second healthy lanes in lane order.
        for (int i = 0; i < 3; i++) begin
            if (!lf[i]) begin
                if (!found) ha = lane[i];
                else        hb = lane[i];
                found = 1'b1;
            end
        end
        case (nf)
            2'd0: begin
                res     = (lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]);
                for (int i = 0; i < 3; i++) dis[i] = (lane[i] != res);
                mm      = |dis;
                advance = 1'b1;
            end
            2'd1: begin
                if (ha == hb) begin
                    res     = ha;
                    advance = 1'b1;
                end else begin
                    unc = 1'b1;
                    mm  = 1'b1;
                end
            end
            2'd2: begin
                res     = ha;
                advance = 1'b1;
            end
            default: unc = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_d[i]  = st_q[i];
            run_d[i] = run_q[i];
            cnt_d[i] = cnt_q[i];
            if (clear_err) begin
                st_d[i]  = StNormal;
                run_d[i] = '0;
                cnt_d[i] = '0;
            end else if (in_valid && advance && st_q[i] != StFaulty) begin
                if (dis[i]) begin
                    if (cnt_q[i] != {CNT_WIDTH{1'b1}}) cnt_d[i] = cnt_q[i] + 1'b1;
                    run_d[i] = run_q[i] + 1'b1;
                    st_d[i]  = (run_d[i] == RunW'(PERSIST)) ? StFaulty : StSuspect;
                end else begin
                    st_d[i]  = StNormal;
                    run_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            tmr_out_q       <= '0;
            mismatch_q      <= 1'b0;
            err_lane_q      <= 3'b000;
            multi_err_q     <= 1'b0;
            uncorrectable_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= StNormal;
                run_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                tmr_out_q       <= res;
                mismatch_q      <= mm;
                err_lane_q      <= dis;
                multi_err_q     <= (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);
                uncorrectable_q <= unc;
            end else begin
                mismatch_q      <= 1'b0;
                err_lane_q      <= 3'b000;
                multi_err_q     <= 1'b0;
                uncorrectable_q <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= st_d[i];
                run_q[i] <= run_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign tmr_out       = tmr_out_q;
    assign mismatch      = mismatch_q;
    assign err_lane      = err_lane_q;
    assign multi_err     = multi_err_q;
    assign uncorrectable = uncorrectable_q;
    assign lane_fault    = lf;

    always_comb begin
        for (int i = 0; i < 3; i++) err_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end

endmodule

// File: tb/tb_tmr_voter_seq.sv
// Scoreboard bench for tmr_voter_seq (WIDTH 4, CNT_WIDTH 2, PERSIST 3).
// Directed samples push hand-computed results; a negedge monitor pops and compares.
module tb_tmr_voter_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] data_1 = '0, data_2 = '0, data_3 = '0;
    logic       clear_err = 1'b0;
    logic       out_valid, mismatch, multi_err, uncorrectable;
    logic [3:0] tmr_out;
    logic [2:0] err_lane, lane_fault;
    logic [5:0] err_cnt;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q[$];
    logic [18:0] last_exp = '0;
    logic [18:0] act, e;

    tmr_voter_seq #(.WIDTH(4), .CNT_WIDTH(2), .PERSIST(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_1       (data_1),
        .data_2       (data_2),
        .data_3       (data_3),
        .clear_err    (clear_err),
        .out_valid    (out_valid),
        .tmr_out      (tmr_out),
        .mismatch     (mismatch),
        .err_lane     (err_lane),
        .multi_err    (multi_err),
        .uncorrectable(uncorrectable),
        .lane_fault   (lane_fault),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Packed as {tmr_out, mismatch, err_lane, multi_err, uncorrectable, lane_fault, cnt3, cnt2, cnt1}
    function automatic logic [18:0] ex(input logic [3:0] t, input logic m, input logic [2:0] el,
                                       input logic mu, input logic un, input logic [2:0] lf,
                                       input int c1, input int c2, input int c3);
        logic [1:0] a, b, c;
        a = 2'(c1);
        b = 2'(c2);
        c = 2'(c3);
        return {t, m, el, mu, un, lf, c, b, a};
    endfunction

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic clr, input logic [18:0] x);
        data_1    = a;
        data_2    = b;
        data_3    = c;
        in_valid  = 1'b1;
        clear_err = clr;
        exp_q.push_back(x);
        last_exp  = x;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            act = {tmr_out, mismatch, err_lane, multi_err, uncorrectable, lane_fault, err_cnt};
            checks++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out_valid: got %h, required no output", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL result @%0t: got %b, required %b", $time, act, e);
                    end
                end
            end else if ({mismatch, err_lane, multi_err, uncorrectable} !== 6'b0) begin
                failures++;
                $display("FAIL idle_flags @%0t: got %b, required 000000", $time,
                         {mismatch, err_lane, multi_err, uncorrectable});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        #12;
        checks++;
        if ({out_valid, tmr_out, mismatch, err_lane, multi_err, uncorrectable, lane_fault, err_cnt}
            !== 20'b0) begin
            failures++;
            $display("FAIL reset_state: got %b, required all zero",
                     {out_valid, tmr_out, mismatch, err_lane, multi_err, uncorrectable,
                      lane_fault, err_cnt});
        end
        @(negedge clk);
        #1 rst = 1'b0;

        // TMR single-lane errors and lane 2 persistence
        send(4'b1111, 4'b1011, 4'b1111, 0, ex(4'b1111, 1, 3'b010, 0, 0, 3'b000, 0, 1, 0));
        send(4'b1011, 4'b1001, 4'b1011, 0, ex(4'b1011, 1, 3'b010, 0, 0, 3'b000, 0, 2, 0));
        send(4'b0101, 4'b0101, 4'b0101, 0, ex(4'b0101, 0, 3'b000, 0, 0, 3'b000, 0, 2, 0));
        send(4'b0011, 4'b0111, 4'b0011, 0, ex(4'b0011, 1, 3'b010, 0, 0, 3'b000, 0, 3, 0));
        send(4'b1100, 4'b1110, 4'b1100, 0, ex(4'b1100, 1, 3'b010, 0, 0, 3'b000, 0, 3, 0));
        send(4'b1111, 4'b0111, 4'b1111, 0, ex(4'b1111, 1, 3'b010, 0, 0, 3'b010, 0, 3, 0));
        // DMR agree, then disagree
        send(4'b1010, 4'b0000, 4'b1010, 0, ex(4'b1010, 0, 3'b000, 0, 0, 3'b010, 0, 3, 0));
        send(4'b1010, 4'b0101, 4'b1000, 0, ex(4'b1010, 1, 3'b000, 0, 1, 3'b010, 0, 3, 0));
        // clear collides with a DMR-uncorrectable sample, next is TMR
        send(4'b1111, 4'b0000, 4'b1110, 1, ex(4'b1010, 1, 3'b000, 0, 1, 3'b000, 0, 0, 0));
        send(4'b1111, 4'b0000, 4'b1110, 0, ex(4'b1110, 1, 3'b011, 1, 0, 3'b000, 1, 1, 0));
        send(4'b0000, 4'b0000, 4'b0000, 0, ex(4'b0000, 0, 3'b000, 0, 0, 3'b000, 1, 1, 0));
        // lane 3 alternates wrong/right: counter saturates at 3, never retires
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0)
                send(4'b0101, 4'b0101, 4'b0100, 0,
                     ex(4'b0101, 1, 3'b100, 0, 0, 3'b000, 1, 1, (k / 2 + 1 > 3) ? 3 : k / 2 + 1));
            else
                send(4'b0101, 4'b0101, 4'b0101, 0,
                     ex(4'b0101, 0, 3'b000, 0, 0, 3'b000, 1, 1, ((k + 1) / 2 > 3) ? 3 : (k + 1) / 2));
        end
        // idle cycles hold tmr_out, lane_fault, err_cnt
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, tmr_out, lane_fault, err_cnt} !==
            {1'b0, last_exp[18:15], last_exp[8:0]}) begin
            failures++;
            $display("FAIL idle_hold: got %b, required %b", {out_valid, tmr_out, lane_fault, err_cnt},
                     {1'b0, last_exp[18:15], last_exp[8:0]});
        end
        // clear alone, then all lanes disagree on distinct bits
        send(4'b0000, 4'b0000, 4'b0000, 1, ex(4'b0000, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            send(4'b0001, 4'b0010, 4'b0100, 0,
                 ex(4'b0000, 1, 3'b111, 1, 0, (k == 2) ? 3'b111 : 3'b000, k + 1, k + 1, k + 1));
        send(4'b1111, 4'b1111, 4'b1111, 0, ex(4'b0000, 0, 3'b000, 0, 1, 3'b111, 3, 3, 3));

        // async reset while a result is presented (not queued: reset wipes it)
        data_1 = 4'b1010; data_2 = 4'b1010; data_3 = 4'b1010;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, uncorrectable, tmr_out} !== 6'b110000) begin
            failures++;
            $display("FAIL pre_reset_out: got %b, required 110000", {out_valid, uncorrectable, tmr_out});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, tmr_out, mismatch, err_lane, multi_err, uncorrectable, lane_fault, err_cnt}
            !== 20'b0) begin
            failures++;
            $display("FAIL async_reset: got %b, required all zero",
                     {out_valid, tmr_out, mismatch, err_lane, multi_err, uncorrectable,
                      lane_fault, err_cnt});
        end
        @(negedge clk);
        #1 rst = 1'b0;
        send(4'b0110, 4'b0110, 4'b0111, 0, ex(4'b0110, 1, 3'b100, 0, 0, 3'b000, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_outputs: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
